// File: rtl/pal_tt_wrapper.sv
// pal_tt_wrapper
// Serially configured PAL block in the TinyTapeout user-macro wrapper.
// A 280-bit configuration register defines an AND plane of 14 product
// terms over 8 inputs and their complements, and an OR plane that
// folds those terms into 4 outputs. The configuration is shifted in
// through the bidirectional pins (data on [0], strobe on [2]) while
// the outputs are disabled ([1] low). All three control pins are
// asynchronous to clk and are brought in through 2-flop synchronizers.

module pal_tt_wrapper #(
    parameter int NUM_INPUTS        = 8,
    parameter int NUM_INTERM_STAGES = 14,
    parameter int NUM_OUTPUTS       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [NUM_INPUTS-1:0] ui_in,
    output logic [7:0]            uo_out,
    input  logic [7:0]            uio_in,
    output logic [7:0]            uio_out,
    output logic [7:0]            uio_oe
);

    // ------------------------------------------------------------------
    // Derived geometry of the configuration bitstream
    // ------------------------------------------------------------------
    localparam int TERM_BITS     = 2 * NUM_INPUTS;
    localparam int AND_BITS      = TERM_BITS * NUM_INTERM_STAGES;
    localparam int OR_BITS       = NUM_INTERM_STAGES * NUM_OUTPUTS;
    localparam int BITSTREAM_LEN = AND_BITS + OR_BITS;

    // ------------------------------------------------------------------
    // Plane evaluation helpers
    // ------------------------------------------------------------------

    // One product term. Bit 2i of sel picks Ii, bit 2i+1 picks ~Ii.
    // A term with nothing selected is 0 rather than the vacuous AND of 1,
    // so unprogrammed terms never leak into the OR plane. Selecting both
    // polarities of one input naturally yields 0.
    function automatic logic eval_term(
        input logic [TERM_BITS-1:0]  sel,
        input logic [NUM_INPUTS-1:0] lits
    );
        logic acc;
        acc = |sel;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            acc = acc & (~sel[2*i] | lits[i]) & (~sel[2*i+1] | ~lits[i]);
        end
        return acc;
    endfunction

    // One sum output: OR of the product terms whose select bit is set.
    function automatic logic eval_output(
        input logic [NUM_INTERM_STAGES-1:0] sel,
        input logic [NUM_INTERM_STAGES-1:0] terms
    );
        return |(sel & terms);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [BITSTREAM_LEN-1:0]     cfg_sr_r;
    logic [1:0]                   data_sync_r;
    logic [1:0]                   oe_sync_r;
    logic [1:0]                   strobe_sync_r;
    logic                         strobe_prev_r;
    logic [7:0]                   uo_out_r;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic                         strobe_rise_s;
    logic                         shift_en_s;
    logic                         out_en_s;
    logic [NUM_INTERM_STAGES-1:0] term_s;
    logic [NUM_OUTPUTS-1:0]       pal_out_s;
    logic [7:0]                   uo_next_s;
    logic                         unused_s;

    // Pins [7:3] of the bidirectional port carry nothing for this design.
    assign unused_s = &{1'b0, uio_in[7:3]};

    // Bring the three asynchronous control pins into the clk domain and
    // remember the previous synchronized strobe for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sync_r   <= 2'b00;
            oe_sync_r     <= 2'b00;
            strobe_sync_r <= 2'b00;
            strobe_prev_r <= 1'b0;
        end else begin
            data_sync_r   <= {data_sync_r[0],   uio_in[0]};
            oe_sync_r     <= {oe_sync_r[0],     uio_in[1]};
            strobe_sync_r <= {strobe_sync_r[0], uio_in[2]};
            strobe_prev_r <= strobe_sync_r[1];
        end
    end

    // Decode the shift and output-enable qualifiers. The edge detector keeps
    // running while shifting is blocked, so a strobe seen while disabled is
    // consumed and cannot fire later when shifting is re-enabled.
    always_comb begin
        strobe_rise_s = strobe_sync_r[1] & ~strobe_prev_r;
        shift_en_s    = 1'b0;
        out_en_s      = 1'b0;
        if (ena) begin
            shift_en_s = strobe_rise_s & ~oe_sync_r[1];
            out_en_s   = oe_sync_r[1];
        end else begin
            shift_en_s = 1'b0;
            out_en_s   = 1'b0;
        end
    end

    // Configuration shift register: new bits enter at the top and walk
    // down, so the first bit of a 280-bit load ends up in bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_sr_r <= '0;
        end else if (shift_en_s) begin
            cfg_sr_r <= {data_sync_r[1], cfg_sr_r[BITSTREAM_LEN-1:1]};
        end else begin
            cfg_sr_r <= cfg_sr_r;
        end
    end

    // AND plane: term t is configured by the 16-bit slice starting at 16*t.
    always_comb begin
        term_s = '0;
        for (int t = 0; t < NUM_INTERM_STAGES; t++) begin
            term_s[t] = eval_term(cfg_sr_r[TERM_BITS*t +: TERM_BITS], ui_in);
        end
    end

    // OR plane: output o is configured by the 14-bit slice that follows the
    // AND plane at offset 224 + 14*o.
    always_comb begin
        pal_out_s = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            pal_out_s[o] = eval_output(
                cfg_sr_r[AND_BITS + NUM_INTERM_STAGES*o +: NUM_INTERM_STAGES],
                term_s);
        end
    end

    // Gate the PAL outputs with the enables; unused output pins stay low.
    always_comb begin
        uo_next_s = 8'h00;
        if (out_en_s) begin
            uo_next_s[NUM_OUTPUTS-1:0] = pal_out_s;
        end else begin
            uo_next_s = 8'h00;
        end
    end

    // Register the output port so it is glitch-free toward the pads.
    always_ff @(posedge clk) begin
        if (rst) begin
            uo_out_r <= 8'h00;
        end else begin
            uo_out_r <= uo_next_s;
        end
    end

    assign uo_out  = uo_out_r;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_pal_tt_wrapper.sv
// tb_pal_tt_wrapper
// Directed bench for pal_tt_wrapper: loads a known PAL program through the
// serial configuration port and checks the resulting logic function, the
// enable/strobe gating, reset behaviour and the strobe edge detector.

module tb_pal_tt_wrapper;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total;
    int bad;

    logic [279:0] cfg;
    logic [7:0]   vec_in  [6];
    logic [7:0]   vec_exp [6];

    pal_tt_wrapper dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one configuration bit following the host timing rules
    task automatic shift_bit(input logic b);
        uio_in[0] = b;
        tick(3);
        uio_in[2] = 1'b1;
        tick(3);
        uio_in[2] = 1'b0;
    endtask

    task automatic load_cfg(input logic [279:0] c, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            shift_bit(c[k]);
        end
        tick(3);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ena = 1'b1;
        uio_in = 8'h02;
        ui_in = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            total++;
            if (uo_out !== 8'h00) begin
                bad++;
                $display("FAIL reset_uo cycle %0d: got %h want 00", k, uo_out);
            end
        end
        rst = 1'b0;
        tick(4);
        total++;
        if (uo_out !== 8'h00) begin
            bad++;
            $display("FAIL blank_cfg: got %h want 00", uo_out);
        end
        total++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            bad++;
            $display("FAIL uio_const_reset: got out=%h oe=%h want 00/00", uio_out, uio_oe);
        end
    endtask

    task automatic test_function;
        uio_in[1] = 1'b0;
        tick(3);
        load_cfg(cfg, 280);
        uio_in[1] = 1'b1;
        tick(3);
        for (int v = 0; v < 6; v++) begin
            ui_in = vec_in[v];
            tick(1);
            total++;
            if (uo_out !== vec_exp[v]) begin
                bad++;
                $display("FAIL func ui=%h: got %h want %h", vec_in[v], uo_out, vec_exp[v]);
            end
        end
        total++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            bad++;
            $display("FAIL uio_const_func: got out=%h oe=%h want 00/00", uio_out, uio_oe);
        end
    endtask

    task automatic test_enable;
        ui_in = 8'h00;
        tick(1);
        total++;
        if (uo_out !== 8'h01) begin
            bad++;
            $display("FAIL en_pre: got %h want 01", uo_out);
        end
        uio_in[1] = 1'b0;
        tick(2);
        total++;
        if (uo_out !== 8'h01) begin
            bad++;
            $display("FAIL en_drop_2clk: got %h want 01", uo_out);
        end
        tick(1);
        total++;
        if (uo_out !== 8'h00) begin
            bad++;
            $display("FAIL en_drop_3clk: got %h want 00", uo_out);
        end
        uio_in[1] = 1'b1;
        tick(2);
        total++;
        if (uo_out !== 8'h00) begin
            bad++;
            $display("FAIL en_rise_2clk: got %h want 00", uo_out);
        end
        tick(1);
        total++;
        if (uo_out !== 8'h01) begin
            bad++;
            $display("FAIL en_rise_3clk: got %h want 01", uo_out);
        end
        ena = 1'b0;
        tick(1);
        total++;
        if (uo_out !== 8'h00) begin
            bad++;
            $display("FAIL ena_low: got %h want 00", uo_out);
        end
        ena = 1'b1;
        tick(1);
        total++;
        if (uo_out !== 8'h01) begin
            bad++;
            $display("FAIL ena_high: got %h want 01", uo_out);
        end
    endtask

    task automatic test_blocked_strobe;
        // outputs enabled: strobes must be ignored
        for (int k = 0; k < 4; k++) shift_bit(1'b1);
        tick(3);
        for (int v = 0; v < 6; v++) begin
            ui_in = vec_in[v];
            tick(1);
            total++;
            if (uo_out !== vec_exp[v]) begin
                bad++;
                $display("FAIL blk_oe ui=%h: got %h want %h", vec_in[v], uo_out, vec_exp[v]);
            end
        end
        // design disabled with outputs off: strobes must also be ignored
        ena = 1'b0;
        uio_in[1] = 1'b0;
        tick(3);
        for (int k = 0; k < 4; k++) shift_bit(1'b1);
        tick(3);
        total++;
        if (uo_out !== 8'h00) begin
            bad++;
            $display("FAIL blk_ena_uo: got %h want 00", uo_out);
        end
        ena = 1'b1;
        tick(2);
        uio_in[1] = 1'b1;
        tick(3);
        for (int v = 0; v < 6; v++) begin
            ui_in = vec_in[v];
            tick(1);
            total++;
            if (uo_out !== vec_exp[v]) begin
                bad++;
                $display("FAIL blk_ena ui=%h: got %h want %h", vec_in[v], uo_out, vec_exp[v]);
            end
        end
    endtask

    task automatic test_reset_midload;
        logic [279:0] ones;
        ones = {280{1'b1}};
        uio_in[1] = 1'b0;
        tick(3);
        load_cfg(ones, 100);
        rst = 1'b1;
        uio_in[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            total++;
            if (uo_out !== 8'h00) begin
                bad++;
                $display("FAIL midload_rst_uo cycle %0d: got %h want 00", k, uo_out);
            end
        end
        uio_in[1] = 1'b0;
        rst = 1'b0;
        tick(3);
        load_cfg(cfg, 280);
        uio_in[1] = 1'b1;
        tick(3);
        for (int v = 0; v < 6; v++) begin
            ui_in = vec_in[v];
            tick(1);
            total++;
            if (uo_out !== vec_exp[v]) begin
                bad++;
                $display("FAIL reload ui=%h: got %h want %h", vec_in[v], uo_out, vec_exp[v]);
            end
        end
    endtask

    // a single long strobe shifts exactly once; one extra 0 bit moves every
    // config bit down by one, giving O0 = I0 | ~I0&I2 and O1 = ~I0&I3
    task automatic test_held_strobe;
        logic [7:0] h_in  [4];
        logic [7:0] h_exp [4];
        h_in[0] = 8'h00; h_exp[0] = 8'h00;
        h_in[1] = 8'h01; h_exp[1] = 8'h01;
        h_in[2] = 8'h08; h_exp[2] = 8'h02;
        h_in[3] = 8'h0C; h_exp[3] = 8'h03;
        uio_in[1] = 1'b0;
        uio_in[0] = 1'b0;
        tick(3);
        uio_in[2] = 1'b1;
        tick(50);
        uio_in[2] = 1'b0;
        tick(3);
        uio_in[1] = 1'b1;
        tick(3);
        for (int v = 0; v < 4; v++) begin
            ui_in = h_in[v];
            tick(1);
            total++;
            if (uo_out !== h_exp[v]) begin
                bad++;
                $display("FAIL held ui=%h: got %h want %h", h_in[v], uo_out, h_exp[v]);
            end
        end
        total++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            bad++;
            $display("FAIL uio_const_end: got out=%h oe=%h want 00/00", uio_out, uio_oe);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        ena = 1'b0;
        ui_in = 8'h00;
        uio_in = 8'h00;

        // O0 = ~I0 | I1&~I2 | I1&~I3 ; O1 = I4&I5
        cfg = '0;
        cfg[1] = 1'b1;   cfg[18] = 1'b1;  cfg[21] = 1'b1;
        cfg[34] = 1'b1;  cfg[39] = 1'b1;  cfg[56] = 1'b1;
        cfg[58] = 1'b1;  cfg[224] = 1'b1; cfg[225] = 1'b1;
        cfg[226] = 1'b1; cfg[241] = 1'b1;

        vec_in[0] = 8'h00; vec_exp[0] = 8'h01;
        vec_in[1] = 8'h01; vec_exp[1] = 8'h00;
        vec_in[2] = 8'h03; vec_exp[2] = 8'h01;
        vec_in[3] = 8'h0F; vec_exp[3] = 8'h00;
        vec_in[4] = 8'h31; vec_exp[4] = 8'h02;
        vec_in[5] = 8'h30; vec_exp[5] = 8'h03;

        tick(2);
        test_reset;
        test_function;
        test_enable;
        test_blocked_strobe;
        test_reset_midload;
        test_held_strobe;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
